// File: rtl/ram_bist_ctrl.sv
// March BIST initiator for a single DPRAM port.
// Sequence: W0(P) up, R0(P)/W1(~P) up, R1(~P) down, then drain the compare pipe.
module ram_bist_ctrl #(
    parameter int Data_Width = 8,
    parameter int RAM_Depth = 16,
    parameter int RD_LAT = 1,
    parameter logic [Data_Width-1:0] PATTERN = 8'hA5,
    localparam int AW = $clog2(RAM_Depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [AW-1:0]         fail_addr,
    output logic [Data_Width-1:0] fail_data,
    output logic                  cs,
    output logic                  oe,
    output logic                  wr_en,
    output logic [AW-1:0]         addr,
    output logic [Data_Width-1:0] data_in,
    input  logic [Data_Width-1:0] data_out
);
    localparam int DW = Data_Width;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [AW-1:0] LAST = AW'(RAM_Depth - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_W0, S_R0W1, S_R1, S_DRAIN, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            ph_q, ph_d;
    logic [CW-1:0]   dr_q, dr_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic            cs_q, cs_d, oe_q, oe_d, we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   din_q, din_d, exp_q, exp_d;
    logic            fail_q, fail_d;
    logic [AW-1:0]   fa_q, fa_d;
    logic [DW-1:0]   fd_q, fd_d;
    logic [RD_LAT-1:0] pv_q;
    logic [AW-1:0]   pa_q [RD_LAT];
    logic [DW-1:0]   pe_q [RD_LAT];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        dr_d    = dr_q;
        fail_d  = fail_q;
        fa_d    = fa_q;
        fd_d    = fd_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_W0;
                    cnt_d   = '0;
                end
            end
            S_W0: begin
                if (cnt_q == LAST) begin
                    state_d = S_R0W1;
                    cnt_d   = '0;
                    ph_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            // ph_q=0 is the read slot, ph_q=1 the write slot of one address
            S_R0W1: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    if (cnt_q == LAST) begin
                        state_d = S_R1;
                        cnt_d   = LAST;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            S_R1: begin
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                    dr_d    = '0;
                end else begin
                    cnt_d = cnt_q - AW'(1);
                end
            end
            S_DRAIN: begin
                if (dr_q == CW'(RD_LAT - 1)) state_d = S_DONE;
                else dr_d = dr_q + CW'(1);
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase

        if (pv_q[RD_LAT-1] && (data_out != pe_q[RD_LAT-1]) && !fail_q) begin
            fail_d = 1'b1;
            fa_d   = pa_q[RD_LAT-1];
            fd_d   = data_out;
        end
        if (state_q == S_IDLE && start) begin
            fail_d = 1'b0;
            fa_d   = '0;
            fd_d   = '0;
        end

        // Bus outputs are decoded from the next state so they leave flops
        busy_d = (state_d == S_W0) || (state_d == S_R0W1) ||
                 (state_d == S_R1) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
        cs_d   = (state_d == S_W0) || (state_d == S_R0W1) || (state_d == S_R1);
        we_d   = (state_d == S_W0) || ((state_d == S_R0W1) && ph_d);
        oe_d   = ((state_d == S_R0W1) && !ph_d) || (state_d == S_R1);
        addr_d = cs_d ? cnt_d : '0;
        din_d  = '0;
        if (state_d == S_W0) din_d = PATTERN;
        else if ((state_d == S_R0W1) && ph_d) din_d = ~PATTERN;
        exp_d  = (state_d == S_R1) ? ~PATTERN : PATTERN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ph_q    <= 1'b0;
            dr_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            exp_q   <= '0;
            fail_q  <= 1'b0;
            fa_q    <= '0;
            fd_q    <= '0;
            pv_q    <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pa_q[i] <= '0;
                pe_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            dr_q    <= dr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            exp_q   <= exp_d;
            fail_q  <= fail_d;
            fa_q    <= fa_d;
            fd_q    <= fd_d;
            pv_q[0] <= oe_q;
            pa_q[0] <= addr_q;
            pe_q[0] <= exp_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pa_q[i] <= pa_q[i-1];
                pe_q[i] <= pe_q[i-1];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_addr = fa_q;
    assign fail_data = fd_q;
    assign cs        = cs_q;
    assign oe        = oe_q;
    assign wr_en     = we_q;
    assign addr      = addr_q;
    assign data_in   = din_q;
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: lane 0 uses RD_LAT=1, lane 1 uses RD_LAT=2,
// each with a faultable RAM model and a scoreboard monitor.
module tb_ram_bist_ctrl;
    typedef struct {
        int busy;
        int fail;
        int fa;
        int fd;
        int rd;
        int wr;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst;
    logic [1:0] start;
    logic [7:0] sa0 [2][16];
    logic [7:0] sa1 [2][16];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int LAT = g + 1;
        logic       busy, done, fail, cs, oe, wr_en;
        logic [3:0] fail_addr, addr;
        logic [7:0] fail_data, data_in, data_out;
        logic [7:0] mem [16];
        logic [7:0] rp [2];

        ram_bist_ctrl #(
            .Data_Width(8), .RAM_Depth(16), .RD_LAT(LAT), .PATTERN(8'hA5)
        ) u_dut (
            .clk(clk), .rst(rst[g]), .start(start[g]),
            .busy(busy), .done(done), .fail(fail),
            .fail_addr(fail_addr), .fail_data(fail_data),
            .cs(cs), .oe(oe), .wr_en(wr_en), .addr(addr),
            .data_in(data_in), .data_out(data_out)
        );

        always @(posedge clk) begin
            if (cs && wr_en) mem[addr] <= data_in;
            rp[0] <= (cs && oe) ?
                     ((mem[addr] & ~sa0[g][addr]) | sa1[g][addr]) : 8'h00;
            rp[1] <= rp[0];
        end
        assign data_out = rp[LAT-1];

        int bc = 0, rd = 0, wr = 0, j;
        logic bprev = 1'b0, dprev = 1'b0;
        logic [2:0] ectl;
        logic [3:0] ea;
        logic [7:0] ed;
        exp_t e;

        always @(negedge clk) begin
            if (busy) begin
                if (!bprev) begin
                    bc = 0; rd = 0; wr = 0;
                    chk($sformatf("l%0d_fail_clr_at_start", g), int'(fail), 0);
                end
                ea = 4'd0; ed = 8'h00;
                if (bc < 16) begin
                    ectl = 3'b101; ea = 4'(bc); ed = 8'hA5;
                end else if (bc < 48) begin
                    j = bc - 16;
                    ectl = (j % 2 == 0) ? 3'b110 : 3'b101;
                    ea = 4'(j / 2);
                    ed = (j % 2 == 0) ? 8'h00 : 8'h5A;
                end else if (bc < 64) begin
                    ectl = 3'b110; ea = 4'(63 - bc);
                end else begin
                    ectl = 3'b000;
                end
                if (ectl[2])
                    chk($sformatf("l%0d_bus_c%0d", g, bc),
                        int'({cs, oe, wr_en, addr, data_in}),
                        int'({ectl, ea, ed}));
                else
                    chk($sformatf("l%0d_drain_ctl_c%0d", g, bc),
                        int'({cs, oe, wr_en}), 0);
                if (cs && oe) rd++;
                if (cs && wr_en) wr++;
                bc++;
            end
            if (done) begin
                chk($sformatf("l%0d_done_single", g), int'(dprev), 0);
                chk($sformatf("l%0d_busy_at_done", g), int'(busy), 0);
                if (sbq.size() == 0) begin
                    chk($sformatf("l%0d_unexpected_done", g), 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("l%0d_busy_cycles", g), bc, e.busy);
                    chk($sformatf("l%0d_fail", g), int'(fail), e.fail);
                    chk($sformatf("l%0d_fail_addr", g), int'(fail_addr), e.fa);
                    chk($sformatf("l%0d_fail_data", g), int'(fail_data), e.fd);
                    chk($sformatf("l%0d_reads", g), rd, e.rd);
                    chk($sformatf("l%0d_writes", g), wr, e.wr);
                end
            end
            bprev = busy;
            dprev = done;
        end
    end

    task automatic clear_faults();
        for (int l = 0; l < 2; l++)
            for (int a = 0; a < 16; a++) begin
                sa0[l][a] = 8'h00;
                sa1[l][a] = 8'h00;
            end
    endtask

    task automatic push(input int b, input int f, input int fa,
                        input int fd);
        exp_t e;
        e = '{b, f, fa, fd, 32, 32};
        sbq.push_back(e);
    endtask

    task automatic pulse(input int l);
        @(negedge clk);
        start[l] = 1'b1;
        @(negedge clk);
        start[l] = 1'b0;
    endtask

    task automatic wait_done(input int l);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if ((l == 0) ? g_lane[0].done : g_lane[1].done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL wait_done_l%0d: done not seen within 300 cycles", l);
        end
    endtask

    initial begin
        rst = 2'b11;
        start = 2'b00;
        clear_faults();
        repeat (3) @(negedge clk);
        chk("reset_state_l0", int'({g_lane[0].busy, g_lane[0].done,
            g_lane[0].cs, g_lane[0].oe, g_lane[0].wr_en, g_lane[0].addr,
            g_lane[0].data_in, g_lane[0].fail, g_lane[0].fail_addr,
            g_lane[0].fail_data}), 0);
        chk("reset_state_l1", int'({g_lane[1].busy, g_lane[1].done,
            g_lane[1].cs, g_lane[1].oe, g_lane[1].wr_en, g_lane[1].addr,
            g_lane[1].data_in, g_lane[1].fail, g_lane[1].fail_addr,
            g_lane[1].fail_data}), 0);
        rst = 2'b00;
        repeat (2) @(negedge clk);

        push(65, 0, 0, 0);
        pulse(0);
        wait_done(0);
        repeat (2) @(negedge clk);

        sa0[0][5] = 8'h01;
        push(65, 1, 5, 8'hA4);
        pulse(0);
        wait_done(0);
        repeat (3) @(negedge clk);
        chk("fail_hold_idle", int'(g_lane[0].fail), 1);
        chk("fail_addr_hold_idle", int'(g_lane[0].fail_addr), 5);
        clear_faults();

        sa1[0][9] = 8'h01;
        sa1[0][12] = 8'h01;
        push(65, 1, 12, 8'h5B);
        pulse(0);
        wait_done(0);
        clear_faults();
        repeat (2) @(negedge clk);

        push(65, 0, 0, 0);
        pulse(0);
        repeat (3) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0);
        repeat (2) @(negedge clk);

        sa0[0][0] = 8'h01;
        pulse(0);
        repeat (19) @(negedge clk);
        chk("fail_before_rst", int'(g_lane[0].fail), 1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("after_rst", int'({g_lane[0].busy, g_lane[0].cs, g_lane[0].oe,
            g_lane[0].wr_en, g_lane[0].addr, g_lane[0].fail}), 0);
        clear_faults();
        push(65, 0, 0, 0);
        pulse(0);
        wait_done(0);
        repeat (2) @(negedge clk);

        push(66, 0, 0, 0);
        pulse(1);
        wait_done(1);
        repeat (2) @(negedge clk);

        sa0[1][0] = 8'h01;
        push(66, 1, 0, 8'hA4);
        pulse(1);
        repeat (18) @(negedge clk);
        chk("lat2_fail_not_yet", int'(g_lane[1].fail), 0);
        @(negedge clk);
        chk("lat2_fail_set", int'(g_lane[1].fail), 1);
        chk("lat2_fail_addr", int'(g_lane[1].fail_addr), 0);
        wait_done(1);
        clear_faults();
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
